adsr_envelope: RTL and testbench
================================

Name: adsr_envelope

Overview:
- Generates a time-varying 9-bit amplitude envelope, 0..256, for one piano voice.
- Output drives the gain input of the amplitude-scaling stage that sits directly downstream; 256 = full scale, 0 = silence.
- Four-phase ADSR state machine (attack, decay, sustain, release), stepped by an internal envelope tick derived from the system clock.

Parameters:
- TICK_DIV, 12000: clk cycles per envelope tick (1 kHz at 12 MHz); must be >= 2.
- ATTACK_STEP, 8: level increment per tick in ATTACK; 1..256.
- DECAY_STEP, 2: level decrement per tick in DECAY; 1..256.
- SUSTAIN_LEVEL, 160: hold level in SUSTAIN; 0..256.
- RELEASE_STEP, 1: level decrement per tick in RELEASE (linear mode); 1..256.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- key_on  input  1  key level; high = pressed; synchronous to clk
- env  output  9  registered envelope level, 0..256
- state  output  3  current phase: 0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, env=0, busy=0, tick counter=0, key_q=0. Reset mid-envelope aborts immediately; no fade.
- Tick counter: free-running, 0..TICK_DIV-1, wraps to 0. tick=1 for one cycle when counter==TICK_DIV-1. Counter is not reset by key events.
- Key edge detection:
  - key_q <= key_on every cycle.
  - rise = key_on & ~key_q; fall = ~key_on & key_q.
- Key-event transitions (any cycle, independent of tick):
  - rise in IDLE or RELEASE -> ATTACK; env is kept, so a retrigger starts from the current level with no click.
  - rise in ATTACK, DECAY or SUSTAIN cannot occur without a prior fall; no action required.
  - fall in ATTACK, DECAY or SUSTAIN -> RELEASE; env is kept.
- Tick transitions (only when tick=1 and no rise/fall that cycle; a key event has priority and env is unchanged in that cycle):
  - ATTACK: env <= min(env+ATTACK_STEP, 256). When the result is 256, state -> DECAY in the same edge. Sum is computed 10 bits wide.
  - DECAY: env <= max(env-DECAY_STEP, SUSTAIN_LEVEL). When the result equals SUSTAIN_LEVEL -> SUSTAIN. If SUSTAIN_LEVEL=256, the first DECAY tick enters SUSTAIN.
  - SUSTAIN: env holds.
  - RELEASE: env <= max(env-RELEASE_STEP, 0). When the result is 0 -> IDLE. Subtraction is guarded against underflow.
  - IDLE: env held at 0.
- Latency:
  - env changes on the same clk edge at which tick is high.
  - State responds one clk after key_on changes (edge-detect register).
- Outputs state and busy are registered. busy is derived from the next state, so busy and state always agree.

Optional Feature:
- ENV_EXP_RELEASE_EN defined:
  - RELEASE decrement per tick = max(env>>3, 1), giving a piano-like exponential tail. RELEASE_STEP is ignored.
  - Reaching 0 -> IDLE as before.
- Not defined: linear RELEASE using RELEASE_STEP, as above.

Test Plan:
- Bench parameters for all scenarios: TICK_DIV=4, ATTACK_STEP=64, DECAY_STEP=16, SUSTAIN_LEVEL=128, RELEASE_STEP=32.
- Reset: hold rst 3 cycles with key_on=1 -> env=0, state=0, busy=0. After release of rst, the key_on rise is detected one cycle later and state=1.
- Full envelope: key_on high -> env 64,128,192,256 on successive ticks, state=2 at 256. Then 240..128 over 8 ticks, state=3 at 128, holds 128 for 20 ticks.
- Release: drop key_on in SUSTAIN -> state=4 next cycle. env 96,64,32,0 on ticks; state=0 and busy=0 at 0.
- Early release: drop key_on when env=128 in ATTACK -> RELEASE from 128, never exceeds 128, reaches 0 after 4 ticks.
- Retrigger: raise key_on when env=64 in RELEASE -> ATTACK; next ticks 128,192,256. Key event coinciding with tick leaves env unchanged that cycle.
- ENV_EXP_RELEASE_EN: RELEASE from 128 -> 112,98,86,76,... The tail decrements by 1 below 8 and reaches 0, then IDLE.

Source files
------------

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope (0..256) for one voice, stepped by an internal tick.
// Define ENV_EXP_RELEASE_EN for an exponential release tail (step = max(env>>3, 1)).
module adsr_envelope #(
    parameter int TICK_DIV      = 12000,
    parameter int ATTACK_STEP   = 8,
    parameter int DECAY_STEP    = 2,
    parameter int SUSTAIN_LEVEL = 160,
    parameter int RELEASE_STEP  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_on,
    output logic [8:0] env,
    output logic [2:0] state,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    localparam int              CNT_W     = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [9:0]      ATK_STEP  = 10'(ATTACK_STEP);
    localparam logic [8:0]      DEC_STEP  = 9'(DECAY_STEP);
    localparam logic [8:0]      SUS_LVL   = 9'(SUSTAIN_LEVEL);
    // Above this level a full decay step still lands at or above sustain.
    localparam logic [10:0]     DEC_FLOOR = 11'(SUSTAIN_LEVEL + DECAY_STEP);

    logic [CNT_W-1:0] cnt_reg;
    logic             key_q_reg;
    state_t           state_reg, state_next;
    logic [8:0]       env_reg, env_next;
    logic             busy_reg;

    logic             tick;
    logic             rise;
    logic             fall;
    logic [9:0]       atk_sum;
    logic [8:0]       rel_dec;

    assign tick = (cnt_reg == CNT_LAST);
    assign rise = key_on & ~key_q_reg;
    assign fall = ~key_on & key_q_reg;

    always_comb begin
        atk_sum = {1'b0, env_reg} + ATK_STEP;
`ifdef ENV_EXP_RELEASE_EN
        rel_dec = (env_reg[8:3] == 6'd0) ? 9'd1 : {3'b000, env_reg[8:3]};
`else
        rel_dec = 9'(RELEASE_STEP);
`endif
    end

    always_comb begin
        state_next = state_reg;
        env_next   = env_reg;
        // Key events win over the tick; env is left untouched on that cycle.
        if (rise && (state_reg == ST_IDLE || state_reg == ST_RELEASE)) begin
            state_next = ST_ATTACK;
        end else if (fall && (state_reg == ST_ATTACK || state_reg == ST_DECAY ||
                              state_reg == ST_SUSTAIN)) begin
            state_next = ST_RELEASE;
        end else if (tick && !rise && !fall) begin
            case (state_reg)
                ST_IDLE: begin
                    env_next = 9'd0;
                end
                ST_ATTACK: begin
                    if (atk_sum >= 10'd256) begin
                        env_next   = 9'd256;
                        state_next = ST_DECAY;
                    end else begin
                        env_next = atk_sum[8:0];
                    end
                end
                ST_DECAY: begin
                    if ({2'b00, env_reg} > DEC_FLOOR) begin
                        env_next = env_reg - DEC_STEP;
                    end else begin
                        env_next   = SUS_LVL;
                        state_next = ST_SUSTAIN;
                    end
                end
                ST_SUSTAIN: begin
                    env_next = env_reg;
                end
                ST_RELEASE: begin
                    if (env_reg > rel_dec) begin
                        env_next = env_reg - rel_dec;
                    end else begin
                        env_next   = 9'd0;
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    env_next   = 9'd0;
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg   <= '0;
            key_q_reg <= 1'b0;
            state_reg <= ST_IDLE;
            env_reg   <= 9'd0;
            busy_reg  <= 1'b0;
        end else begin
            cnt_reg   <= tick ? '0 : cnt_reg + CNT_W'(1);
            key_q_reg <= key_on;
            state_reg <= state_next;
            env_reg   <= env_next;
            busy_reg  <= (state_next != ST_IDLE);
        end
    end

    assign env   = env_reg;
    assign state = state_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed scoreboard bench for adsr_envelope: expectations are queued before each
// clock edge and popped/compared 1 time unit after it.
module tb_adsr_envelope;

    localparam int TICK_DIV      = 4;
    localparam int ATTACK_STEP   = 64;
    localparam int DECAY_STEP    = 16;
    localparam int SUSTAIN_LEVEL = 128;
    localparam int RELEASE_STEP  = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_on = 1'b0;
    logic [8:0] env;
    logic [2:0] state;
    logic       busy;

    adsr_envelope #(
        .TICK_DIV     (TICK_DIV),
        .ATTACK_STEP  (ATTACK_STEP),
        .DECAY_STEP   (DECAY_STEP),
        .SUSTAIN_LEVEL(SUSTAIN_LEVEL),
        .RELEASE_STEP (RELEASE_STEP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .key_on(key_on),
        .env   (env),
        .state (state),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] env;
        logic [2:0] st;
        logic       busy;
    } exp_t;

    exp_t       sb_q[$];
    int         errors = 0;
    int         checks = 0;
    int         phase  = 0;
    logic [8:0] cur_env  = '0;
    logic [2:0] cur_st   = '0;
    logic       cur_busy = 1'b0;

    // One clock edge: queue the expectation, clock, then pop and compare.
    task automatic step(input string tag, input int e, input int s, input int b);
        exp_t x;
        sb_q.push_back('{env: 9'(e), st: 3'(s), busy: 1'(b)});
        @(posedge clk);
        if (!rst) phase = (phase + 1) % TICK_DIV;
        cur_env  = 9'(e);
        cur_st   = 3'(s);
        cur_busy = 1'(b);
        #1;
        x = sb_q.pop_front();
        checks++;
        assert (env === x.env && state === x.st && busy === x.busy) else begin
            errors++;
            $error("FAIL %s: env/state/busy got=%0d/%0d/%0d want=%0d/%0d/%0d",
                   tag, env, state, busy, x.env, x.st, x.busy);
        end
    endtask

    // Non-tick edges: outputs must hold their last expected values.
    task automatic hold_to_tick(input string tag);
        while (phase != TICK_DIV - 1) step(tag, int'(cur_env), int'(cur_st), int'(cur_busy));
    endtask

    task automatic tick(input string tag, input int e, input int s, input int b);
        hold_to_tick({tag, "_hold"});
        step(tag, e, s, b);
    endtask

    task automatic key(input string tag, input logic k, input int e, input int s, input int b);
        key_on = k;
        step(tag, e, s, b);
    endtask

    function automatic int rel_next(input int e);
        int d;
`ifdef ENV_EXP_RELEASE_EN
        d = e >> 3;
        if (d < 1) d = 1;
`else
        d = RELEASE_STEP;
`endif
        return (e > d) ? e - d : 0;
    endfunction

    task automatic release_to_zero(input string tag);
        int e;
        e = int'(cur_env);
        for (int i = 0; i < 300 && e > 0; i++) begin
            e = rel_next(e);
            tick(tag, e, (e == 0) ? 0 : 4, (e != 0) ? 1 : 0);
        end
    endtask

    initial begin
        int e;
        // Reset with the key already held: no rise may be seen until reset ends.
        rst    = 1'b1;
        key_on = 1'b1;
        for (int i = 0; i < 3; i++) step("reset", 0, 0, 0);
        rst = 1'b0;
        step("rise_after_rst", 0, 1, 1);

        tick("attack1", 64, 1, 1);
        tick("attack2", 128, 1, 1);
        tick("attack3", 192, 1, 1);
        tick("attack_top", 256, 2, 1);
        for (int k = 1; k <= 8; k++) begin
            e = 256 - 16 * k;
            tick("decay", e, (e == 128) ? 3 : 2, 1);
        end
        for (int i = 0; i < 20; i++) tick("sustain", 128, 3, 1);

        key("release_fall", 1'b0, 128, 4, 1);
        release_to_zero("release");
        step("idle_after_rel", 0, 0, 0);

        // Early release from the middle of ATTACK.
        key("press2", 1'b1, 0, 1, 1);
        tick("attack2_1", 64, 1, 1);
        tick("attack2_2", 128, 1, 1);
        key("early_fall", 1'b0, 128, 4, 1);
`ifdef ENV_EXP_RELEASE_EN
        tick("exp_rel1", 112, 4, 1);
        tick("exp_rel2", 98, 4, 1);
        tick("exp_rel3", 86, 4, 1);
        tick("exp_rel4", 76, 4, 1);
        release_to_zero("exp_tail");
`else
        tick("early_rel1", 96, 4, 1);
        tick("early_rel2", 64, 4, 1);
        tick("early_rel3", 32, 4, 1);
        tick("early_rel4", 0, 0, 0);
`endif

        // Retrigger from RELEASE, with both key edges landing on tick cycles.
        key("press3", 1'b1, 0, 1, 1);
        tick("attack3_1", 64, 1, 1);
        tick("attack3_2", 128, 1, 1);
        tick("attack3_3", 192, 1, 1);
        tick("attack3_top", 256, 2, 1);
        hold_to_tick("pre_fall_hold");
        key("fall_on_tick", 1'b0, 256, 4, 1);
        e = 256;
        for (int i = 0; i < 300 && e > 64; i++) begin
            e = rel_next(e);
            tick("rel_to_64", e, (e == 0) ? 0 : 4, (e != 0) ? 1 : 0);
        end
        hold_to_tick("pre_rise_hold");
        key("rise_on_tick", 1'b1, e, 1, 1);
        for (int i = 0; i < 10 && e < 256; i++) begin
            e = (e + 64 > 256) ? 256 : e + 64;
            tick("retrig_attack", e, (e == 256) ? 2 : 1, 1);
        end
        key("final_fall", 1'b0, 256, 4, 1);
        release_to_zero("final_release");
        step("idle_end1", 0, 0, 0);
        step("idle_end2", 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
